// File: rtl/i2s_tx_sched.sv
// Stereo transmit scheduler in front of an I2S core's valid/ready sample port.
// Left and right samples queue in separate FIFOs; on every word-select edge the
// sample for the new slot is chosen according to the channel mode and offered
// to the core, with underrun and late-slot errors reported and counted.
module i2s_tx_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          en_i,
  input  logic [1:0]                    chm_i,
  input  logic                          i2s_ws_i,
  input  logic                          l_valid_i,
  output logic                          l_ready_o,
  input  logic [DATA_WIDTH-1:0]         l_data_i,
  input  logic                          r_valid_i,
  output logic                          r_ready_o,
  input  logic [DATA_WIDTH-1:0]         r_data_i,
  output logic                          core_tx_valid_o,
  input  logic                          core_tx_ready_i,
  output logic [DATA_WIDTH-1:0]         core_tx_data_o,
  output logic                          lr_o,
  output logic                          busy_o,
  output logic                          underrun_o,
  output logic                          late_o,
  output logic [15:0]                   err_cnt_o,
  output logic [$clog2(FIFO_DEPTH):0]   l_level_o,
  output logic [$clog2(FIFO_DEPTH):0]   r_level_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SYNC, WAIT, ISSUE} state_t;

  // Channel-indexed FIFO plumbing: index 0 = left, 1 = right.
  logic [1:0]                 in_valid;
  logic [1:0][DATA_WIDTH-1:0] in_data;
  logic [1:0]                 fifo_rdy;
  logic [1:0]                 fifo_empty;
  logic [1:0]                 push;
  logic [1:0]                 pop;
  logic [1:0][DATA_WIDTH-1:0] head;
  logic [1:0][CW-1:0]         level;

  assign in_valid   = {r_valid_i, l_valid_i};
  assign in_data[0] = l_data_i;
  assign in_data[1] = r_data_i;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
      logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
      logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
      logic [CW-1:0]         cnt_q, cnt_d;

      // Ready depends only on the registered count, so a same-cycle pop never frees a slot early.
      assign fifo_rdy[gi]   = en_i & (cnt_q != DEPTH_C);
      assign fifo_empty[gi] = (cnt_q == '0);
      assign push[gi]       = in_valid[gi] & fifo_rdy[gi];
      assign head[gi]       = mem_q[rd_ptr_q];
      assign level[gi]      = cnt_q;

      // Pointer/count update; disabling the scheduler flushes the FIFO.
      always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (!en_i) begin
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          cnt_d    = '0;
        end else begin
          if (push[gi]) wr_ptr_d = wr_ptr_q + AW'(1);
          if (pop[gi])  rd_ptr_d = rd_ptr_q + AW'(1);
          case ({push[gi], pop[gi]})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
          endcase
        end
      end

      // FIFO pointer and count registers.
      always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          cnt_q    <= '0;
        end else begin
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
          cnt_q    <= cnt_d;
        end
      end

      // Sample storage; contents need no reset because the count gates every read.
      always_ff @(posedge clk_i) begin
        if (push[gi]) mem_q[wr_ptr_q] <= in_data[gi];
      end
    end
  endgenerate

  state_t                state_q, state_d;
  logic                  ws_q, ws_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] last_l_q, last_l_d;
  logic                  lr_q, lr_d;
  logic                  und_q, und_d;
  logic                  late_q, late_d;
  logic [15:0]           err_q, err_d;

  logic ws_edge, hs, slot, need, src;

  // Slot scheduling FSM: detects WS edges, selects/pops the slot sample and flags errors.
  always_comb begin
    state_d  = state_q;
    ws_d     = i2s_ws_i;
    data_d   = data_q;
    last_l_d = last_l_q;
    lr_d     = lr_q;
    und_d    = 1'b0;
    late_d   = 1'b0;
    pop      = 2'b00;
    slot     = 1'b0;
    need     = 1'b0;
    src      = i2s_ws_i;
    ws_edge  = (i2s_ws_i != ws_q);
    hs       = (state_q == ISSUE) & core_tx_ready_i;

    if (!en_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:  state_d = SYNC;
        // Only a falling WS (entry into a left slot) starts the schedule.
        SYNC:  if (ws_edge && !i2s_ws_i) slot = 1'b1;
        WAIT:  if (ws_edge) slot = 1'b1;
        ISSUE: begin
          if (ws_edge) begin
            slot   = 1'b1;
            late_d = ~hs;
          end else if (hs) begin
            state_d = WAIT;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (slot) begin
      state_d = ISSUE;
      lr_d    = i2s_ws_i;
      // Mode 00 always pops its own channel; 01/10 pop only their own slot; 11 pops only in the left slot.
      case (chm_i)
        2'b00:   need = 1'b1;
        2'b01:   need = ~i2s_ws_i;
        2'b10:   need = i2s_ws_i;
        default: need = ~i2s_ws_i;
      endcase
      if (need) begin
        if (!fifo_empty[src]) begin
          pop[src] = 1'b1;
          data_d   = head[src];
        end else begin
          data_d = '0;
          und_d  = 1'b1;
        end
      end else if (chm_i == 2'b11) begin
        data_d = last_l_q;
      end else begin
        data_d = '0;
      end
      if (chm_i == 2'b11 && !i2s_ws_i) last_l_d = data_d;
    end
  end

  // Saturating error counter: one step per cycle with any error pulse.
  always_comb begin
    err_d = err_q;
    if ((und_d | late_d) && err_q != 16'hFFFF) err_d = err_q + 16'd1;
  end

  // Scheduler state registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      ws_q     <= 1'b0;
      data_q   <= '0;
      last_l_q <= '0;
      lr_q     <= 1'b0;
      und_q    <= 1'b0;
      late_q   <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      ws_q     <= ws_d;
      data_q   <= data_d;
      last_l_q <= last_l_d;
      lr_q     <= lr_d;
      und_q    <= und_d;
      late_q   <= late_d;
      err_q    <= err_d;
    end
  end

  assign core_tx_valid_o = (state_q == ISSUE);
  assign core_tx_data_o  = data_q;
  assign busy_o          = (state_q == WAIT) || (state_q == ISSUE);
  assign lr_o            = lr_q;
  assign underrun_o      = und_q;
  assign late_o          = late_q;
  assign err_cnt_o       = err_q;
  assign l_ready_o       = fifo_rdy[0];
  assign r_ready_o       = fifo_rdy[1];
  assign l_level_o       = level[0];
  assign r_level_o       = level[1];

endmodule

// File: tb/tb_i2s_tx_sched.sv
// Bench for i2s_tx_sched: directed scenarios followed by random traffic, checked
// against a queue-based reference model through two scoreboard streams
// (per-cycle status, and samples accepted by the core).
module tb_i2s_tx_sched;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int LW    = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, en, ws, lv, rv, rdy;
  logic [1:0]    chm;
  logic [DW-1:0] ld, rd;
  logic          l_ready, r_ready, tx_valid, lr, busy, und, late;
  logic [DW-1:0] tx_data;
  logic [15:0]   err;
  logic [LW-1:0] llev, rlev;

  i2s_tx_sched #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .chm_i(chm), .i2s_ws_i(ws),
    .l_valid_i(lv), .l_ready_o(l_ready), .l_data_i(ld),
    .r_valid_i(rv), .r_ready_o(r_ready), .r_data_i(rd),
    .core_tx_valid_o(tx_valid), .core_tx_ready_i(rdy), .core_tx_data_o(tx_data),
    .lr_o(lr), .busy_o(busy), .underrun_o(und), .late_o(late), .err_cnt_o(err),
    .l_level_o(llev), .r_level_o(rlev)
  );

  typedef struct packed {
    logic          valid;
    logic          busy;
    logic          lr;
    logic          und;
    logic          late;
    logic          lrdy;
    logic          rrdy;
    logic [15:0]   err;
    logic [LW-1:0] llev;
    logic [LW-1:0] rlev;
  } stat_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          lr;
  } tx_t;

  stat_t exp_stat[$];
  tx_t   exp_tx[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  // Reference model state (values as seen after the most recent clock edge).
  logic [DW-1:0] lq[$];
  logic [DW-1:0] rq[$];
  bit            m_ws_prev, m_active, m_aligned, m_pending, m_lr;
  logic [DW-1:0] m_pend_data, m_last_l;
  logic [15:0]   m_err;

  function automatic string fmt(stat_t s);
    return $sformatf("valid=%0b busy=%0b lr=%0b und=%0b late=%0b lrdy=%0b rrdy=%0b err=%h llev=%0d rlev=%0d",
                     s.valid, s.busy, s.lr, s.und, s.late, s.lrdy, s.rrdy, s.err, s.llev, s.rlev);
  endfunction

  // Predicts the effect of the upcoming clock edge from the currently driven inputs.
  task automatic model_step();
    bit            hs, edge_seen, slot, need, und_n, late_n, lrdy, rrdy;
    logic [DW-1:0] v;
    stat_t         s;
    hs     = m_pending && rdy;
    und_n  = 1'b0;
    late_n = 1'b0;
    if (hs) exp_tx.push_back({m_pend_data, m_lr});
    if (!rst_n) begin
      m_ws_prev = 0; m_active = 0; m_aligned = 0; m_pending = 0; m_lr = 0;
      m_err = '0; m_last_l = '0; m_pend_data = '0;
      lq.delete(); rq.delete();
    end else begin
      edge_seen = (ws != m_ws_prev);
      lrdy = en && (lq.size() < DEPTH);
      rrdy = en && (rq.size() < DEPTH);
      if (!en) begin
        m_active = 0; m_aligned = 0; m_pending = 0;
        lq.delete(); rq.delete();
      end else begin
        slot = 0;
        if (!m_active) m_active = 1;
        else if (!m_aligned) begin
          if (edge_seen && ws == 1'b0) begin slot = 1; m_aligned = 1; end
        end else if (edge_seen) begin
          slot = 1;
          if (m_pending && !hs) late_n = 1;
        end else if (hs) m_pending = 0;
        if (slot) begin
          need = (chm == 2'b00) || (chm == 2'b01 && !ws) || (chm == 2'b10 && ws) || (chm == 2'b11 && !ws);
          if (need) begin
            if (!ws && lq.size() > 0)     v = lq.pop_front();
            else if (ws && rq.size() > 0) v = rq.pop_front();
            else begin v = '0; und_n = 1; end
          end else v = (chm == 2'b11) ? m_last_l : '0;
          if (chm == 2'b11 && !ws) m_last_l = v;
          m_pending   = 1;
          m_pend_data = v;
          m_lr        = ws;
        end
        if (lv && lrdy) lq.push_back(ld);
        if (rv && rrdy) rq.push_back(rd);
      end
      m_ws_prev = ws;
      if ((und_n || late_n) && m_err != 16'hFFFF) m_err = m_err + 16'd1;
    end
    s.valid = m_pending;
    s.busy  = m_aligned;
    s.lr    = m_lr;
    s.und   = und_n;
    s.late  = late_n;
    s.lrdy  = en && (lq.size() < DEPTH);
    s.rrdy  = en && (rq.size() < DEPTH);
    s.err   = m_err;
    s.llev  = LW'(lq.size());
    s.rlev  = LW'(rq.size());
    exp_stat.push_back(s);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #2;
  endtask

  task automatic hold(int n);
    repeat (n) tick();
  endtask

  // Status monitor: one comparison per cycle, shortly after the active edge.
  initial begin
    stat_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_stat.size() > 0) begin
        e = exp_stat.pop_front();
        a = {tx_valid, busy, lr, und, late, l_ready, r_ready, err, llev, rlev};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          if (n_bad <= 30) $display("FAIL status @%0t: actual %s | required %s", $time, fmt(a), fmt(e));
        end
      end
    end
  end

  // Sample monitor: every handshake with the core must match the next predicted sample.
  initial begin
    tx_t e;
    forever begin
      @(negedge clk);
      if (tx_valid === 1'b1 && rdy === 1'b1) begin
        n_cmp++;
        if (exp_tx.size() == 0) begin
          n_bad++;
          if (n_bad <= 30) $display("FAIL tx_unexpected @%0t: actual data=%h lr=%0b required no transfer", $time, tx_data, lr);
        end else begin
          e = exp_tx.pop_front();
          if ({tx_data, lr} !== e) begin
            n_bad++;
            if (n_bad <= 30) $display("FAIL tx_sample @%0t: actual data=%h lr=%0b required data=%h lr=%0b",
                                      $time, tx_data, lr, e.data, e.lr);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 0; en = 0; chm = 2'b00; ws = 0; lv = 0; rv = 0; rdy = 0; ld = '0; rd = '0;
    hold(3);
    rst_n = 1;
    hold(2);

    // Stereo with start alignment: enabled while WS = 1, samples queued, 64-cycle WS period.
    ws = 1; en = 1; rdy = 1;
    for (int i = 0; i < 4; i++) begin
      lv = 1; ld = 32'hA000_0000 + i;
      rv = 1; rd = 32'hB000_0000 + i;
      tick();
    end
    lv = 0; rv = 0;
    hold(5);
    for (int k = 0; k < 8; k++) begin ws = ~ws; hold(32); end

    // Underrun: one left sample only, right slot finds its FIFO empty.
    lv = 1; ld = 32'hC0C0_0001; tick(); lv = 0;
    ws = 0; hold(32);
    ws = 1; hold(32);

    // Late: core stalls across a slot edge.
    lv = 1; ld = 32'hD000_0000; rv = 1; rd = 32'hD000_0001; tick(); lv = 0; rv = 0;
    rdy = 0;
    ws = 0; hold(10);
    ws = 1; hold(3);
    rdy = 1; hold(20);

    // Mono-dup: right FIFO content must stay untouched.
    chm = 2'b11;
    lv = 1; ld = 32'h0000_1234; rv = 1; rd = 32'h5555_5555; tick(); lv = 0; rv = 0;
    ws = 0; hold(32);
    ws = 1; hold(32);

    // Full FIFO then disable: five pushes offered without any slot edge.
    chm = 2'b00;
    for (int i = 0; i < 5; i++) begin lv = 1; ld = 32'hF000_0000 + i; tick(); end
    lv = 0; hold(3);
    en = 0; hold(4);
    en = 1; hold(2);

    // Random traffic with mode changes, short disables and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(1499) != 0);
      en    = ($urandom_range(399) != 0);
      if ($urandom_range(199) == 0) chm = 2'($urandom_range(3));
      if ($urandom_range(11) == 0) ws = ~ws;
      lv  = ($urandom_range(99) < 35); ld = $urandom;
      rv  = ($urandom_range(99) < 35); rd = $urandom;
      rdy = ($urandom_range(99) < 75);
      tick();
    end
    rst_n = 1; en = 1; lv = 0; rv = 0;

    // Saturation: a slot edge every cycle with the core stalled and FIFOs drained.
    chm = 2'b00; rdy = 0;
    repeat (65545) begin ws = ~ws; tick(); end
    rdy = 1; hold(3);

    @(posedge clk);
    #3;
    n_cmp++;
    if (exp_tx.size() != 0) begin
      n_bad++;
      $display("FAIL tx_drain: actual %0d predicted samples never transferred, required 0", exp_tx.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
